// File: rtl/mem_stage_sequencer_pkg.sv
// Shared types for the LC-3b MEM-stage data-cache sequencer: opcodes, FSM state,
// access kinds and the kind-decode helpers used by the datapath.
package mem_stage_sequencer_pkg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS1 = 2'd1,
      ACCESS2 = 2'd2
   } mem_seq_state_t;

   typedef enum logic [1:0] {
      MK_LOAD  = 2'd0,
      MK_STORE = 2'd1,
      MK_LDI   = 2'd2,
      MK_STI   = 2'd3
   } mem_kind_t;

   localparam logic [1:0] BE_WORD = 2'b11;

   // A write request wins over a simultaneous read request.
   function automatic mem_kind_t decode_kind(input logic is_write, input logic is_indirect);
      mem_kind_t kind;
      case ({is_write, is_indirect})
         2'b00:   kind = MK_LOAD;
         2'b01:   kind = MK_LDI;
         2'b10:   kind = MK_STORE;
         2'b11:   kind = MK_STI;
         default: kind = MK_LOAD;
      endcase
      return kind;
   endfunction

   function automatic logic kind_is_indirect(input mem_kind_t kind);
      return (kind == MK_LDI) || (kind == MK_STI);
   endfunction

endpackage

// File: rtl/mem_stage_sequencer_if.sv
// Data-cache request/response port between the MEM-stage sequencer (master)
// and the data cache (slave).
interface mem_stage_sequencer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  dmem_read;
   logic                  dmem_write;
   logic [1:0]            dmem_byte_enable;
   logic [DATA_WIDTH-1:0] dmem_address;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic [DATA_WIDTH-1:0] dmem_rdata;
   logic                  dmem_resp;

   modport master (
      output dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
      input  dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
      output dmem_rdata, dmem_resp
   );
endinterface

// File: rtl/mem_stage_sequencer_chk.sv
// Protocol checks on the control-word fields presented to the MEM-stage sequencer.
module mem_stage_sequencer_chk
   import mem_stage_sequencer_pkg::*;
(
   input logic       clk,
   input logic       reset_n,
   input logic       valid_i,
   input logic       flush_i,
   input lc3b_opcode opcode_i,
   input logic       mem_read_i,
   input logic       mem_write_i,
   input logic       indirect_i
);
   a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      !(valid_i && !flush_i && mem_read_i && mem_write_i))
      else $error("mem_stage_sequencer: mem_read and mem_write both set, write wins");

   a_indirect_opcode: assert property (@(posedge clk) disable iff (!reset_n)
      (valid_i && !flush_i && indirect_i && (mem_read_i || mem_write_i))
         |-> ((opcode_i == op_ldi) || (opcode_i == op_sti)))
      else $error("mem_stage_sequencer: indirect access with non LDI/STI opcode");
endmodule

// File: rtl/mem_stage_sequencer_watchdog.sv
// Response watchdog: counts cycles spent waiting on the cache and raises a
// sticky error once TIMEOUT_CYCLES is reached (0 disables the error).
module mem_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic active_i,
   input  logic clear_i,
   output logic timeout_err
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
   localparam logic ENABLE = (TIMEOUT_CYCLES > 0);

   logic [CNT_W-1:0] cnt_r;
   logic             err_r;
   logic             expire_s;

   // Expiry is the cycle in which the counter would step past its limit.
   always_comb begin
      expire_s = 1'b0;
      if (ENABLE && active_i && !clear_i && (cnt_r == LIMIT_C)) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Saturating wait counter plus sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {CNT_W{1'b0}};
         err_r <= 1'b0;
      end else begin
         if (clear_i || !active_i) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_r != LIMIT_C) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (expire_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign timeout_err = err_r;
endmodule

// File: rtl/mem_stage_sequencer.sv
// LC-3b MEM-stage sequencer: turns control-word memory fields into data-cache
// transactions, including the two-access LDI/STI walk, and stalls until done.
module mem_stage_sequencer
   import mem_stage_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  lc3b_opcode            opcode_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic                  indirect_i,
   input  logic [1:0]            byte_en_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   mem_stage_sequencer_if.master dmem,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  timeout_err
);
   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_ACCESS1 = ACCESS1;
   localparam logic [1:0] S_ACCESS2 = ACCESS2;
   localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

   logic [1:0]            state_r, next_state_s;
   mem_kind_t             kind_r, req_kind_s;
   logic [DATA_WIDTH-1:0] wdata_r, data_r;
   logic                  squash_r, squash_eff_s;
   logic                  req_s, resp_s, stall_s, done_s, load_done_s;

   logic                  dmem_read_r, dmem_write_r;
   logic [1:0]            dmem_be_r;
   logic [DATA_WIDTH-1:0] dmem_addr_r, dmem_wdata_r;
   logic                  nxt_read_s, nxt_write_s;
   logic [1:0]            nxt_be_s;
   logic [DATA_WIDTH-1:0] nxt_addr_s, nxt_wdata_s;

   assign req_s        = valid_i & ~flush_i & (mem_read_i | mem_write_i);
   assign req_kind_s   = decode_kind(mem_write_i, indirect_i);
   assign resp_s       = dmem.dmem_resp;
   assign squash_eff_s = squash_r | flush_i;

   // Next state, stall and completion decode; a squashed access never completes.
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      done_s       = 1'b0;
      load_done_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            stall_s = req_s;
            if (req_s) begin
               next_state_s = S_ACCESS1;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_ACCESS1: begin
            if (!resp_s) begin
               stall_s = 1'b1;
            end else if (kind_is_indirect(kind_r) && !squash_eff_s) begin
               stall_s      = 1'b1;
               next_state_s = S_ACCESS2;
            end else begin
               next_state_s = S_IDLE;
               done_s       = ~squash_eff_s;
               load_done_s  = ~squash_eff_s & (kind_r == MK_LOAD);
            end
         end
         S_ACCESS2: begin
            if (resp_s) begin
               next_state_s = S_IDLE;
               done_s       = ~squash_eff_s;
               load_done_s  = ~squash_eff_s & (kind_r == MK_LDI);
            end else begin
               stall_s = 1'b1;
            end
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   // Next cache-port values; the port only changes on state transitions.
   always_comb begin
      nxt_read_s  = 1'b0;
      nxt_write_s = 1'b0;
      nxt_be_s    = 2'b00;
      nxt_addr_s  = ZERO_W;
      nxt_wdata_s = ZERO_W;
      case (state_r)
         S_IDLE: begin
            if (req_s && (req_kind_s == MK_STORE)) begin
               nxt_write_s = 1'b1;
               nxt_be_s    = byte_en_i;
               nxt_addr_s  = addr_i;
               nxt_wdata_s = wdata_i;
            end else if (req_s) begin
               nxt_read_s = 1'b1;
               nxt_be_s   = BE_WORD;
               nxt_addr_s = addr_i;
            end else begin
               nxt_read_s = 1'b0;
            end
         end
         S_ACCESS1, S_ACCESS2: begin
            if (!resp_s) begin
               nxt_read_s  = dmem_read_r;
               nxt_write_s = dmem_write_r;
               nxt_be_s    = dmem_be_r;
               nxt_addr_s  = dmem_addr_r;
               nxt_wdata_s = dmem_wdata_r;
            end else if (next_state_s == S_ACCESS2) begin
               // The fetched pointer is word-aligned before the second access.
               nxt_read_s  = (kind_r == MK_LDI);
               nxt_write_s = (kind_r == MK_STI);
               nxt_be_s    = BE_WORD;
               nxt_addr_s  = {dmem.dmem_rdata[DATA_WIDTH-1:1], 1'b0};
               nxt_wdata_s = (kind_r == MK_STI) ? wdata_r : ZERO_W;
            end else begin
               nxt_read_s = 1'b0;
            end
         end
         default: begin
            nxt_read_s = 1'b0;
         end
      endcase
   end

   // FSM state, request latches, squash flag and load-data register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= S_IDLE;
         kind_r   <= MK_LOAD;
         wdata_r  <= ZERO_W;
         squash_r <= 1'b0;
         data_r   <= ZERO_W;
      end else begin
         state_r  <= next_state_s;
         squash_r <= (state_r != S_IDLE) && (next_state_s != S_IDLE) && squash_eff_s;
         if ((state_r == S_IDLE) && req_s) begin
            kind_r  <= req_kind_s;
            wdata_r <= wdata_i;
         end
         if (load_done_s) begin
            data_r <= dmem.dmem_rdata;
         end
      end
   end

   // Registered cache port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dmem_read_r  <= 1'b0;
         dmem_write_r <= 1'b0;
         dmem_be_r    <= 2'b00;
         dmem_addr_r  <= ZERO_W;
         dmem_wdata_r <= ZERO_W;
      end else begin
         dmem_read_r  <= nxt_read_s;
         dmem_write_r <= nxt_write_s;
         dmem_be_r    <= nxt_be_s;
         dmem_addr_r  <= nxt_addr_s;
         dmem_wdata_r <= nxt_wdata_s;
      end
   end

   assign dmem.dmem_read        = dmem_read_r;
   assign dmem.dmem_write       = dmem_write_r;
   assign dmem.dmem_byte_enable = dmem_be_r;
   assign dmem.dmem_address     = dmem_addr_r;
   assign dmem.dmem_wdata       = dmem_wdata_r;

   assign stall_o = stall_s;
   assign done_o  = done_s;
   assign rdata_o = load_done_s ? dmem.dmem_rdata : data_r;

   mem_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk         (clk),
      .reset_n     (reset_n),
      .active_i    (state_r != S_IDLE),
      .clear_i     (resp_s | (next_state_s != state_r)),
      .timeout_err (timeout_err)
   );

   mem_stage_sequencer_chk u_chk (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_i     (valid_i),
      .flush_i     (flush_i),
      .opcode_i    (opcode_i),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .indirect_i  (indirect_i)
   );
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed self-checking bench for mem_stage_sequencer with a load-data scoreboard.
module tb_mem_stage_sequencer;
   import mem_stage_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_i, flush_i, mem_read_i, mem_write_i, indirect_i;
   lc3b_opcode  opcode_i;
   logic [1:0]  byte_en_i;
   logic [15:0] addr_i, wdata_i;
   logic        stall_o, done_o, timeout_err;
   logic [15:0] rdata_o;

   int          checks = 0;
   int          errors = 0;
   int          done_seen = 0;
   logic [15:0] exp_q[$];

   mem_stage_sequencer_if #(.DATA_WIDTH(16)) bus ();

   mem_stage_sequencer #(
      .DATA_WIDTH     (16),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_i     (valid_i),
      .flush_i     (flush_i),
      .opcode_i    (opcode_i),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .indirect_i  (indirect_i),
      .byte_en_i   (byte_en_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .dmem        (bus),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .rdata_o     (rdata_o),
      .timeout_err (timeout_err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_resp(input logic r, input logic [15:0] d);
      bus.dmem_resp  = r;
      bus.dmem_rdata = d;
   endtask

   // Presents one request in an IDLE cycle, checks the detect cycle, then withdraws it.
   task automatic drive_req(input lc3b_opcode op, input logic rd, input logic wr,
                            input logic ind, input logic [1:0] be,
                            input logic [15:0] a, input logic [15:0] wd);
      opcode_i = op; mem_read_i = rd; mem_write_i = wr; indirect_i = ind;
      byte_en_i = be; addr_i = a; wdata_i = wd; valid_i = 1'b1;
      #1;
      chk("detect_stall", stall_o, 1);
      chk("detect_no_read", bus.dmem_read, 0);
      chk("detect_no_write", bus.dmem_write, 0);
      next_cycle();
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; indirect_i = 1'b0;
   endtask

   // Scoreboard: every completion must match the oldest expected rdata_o.
   always @(negedge clk) begin
      if (done_o === 1'b1) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            chk("sb_pending", 32'(exp_q.size()), 32'd1);
         end else begin
            chk("sb_rdata", rdata_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      reset_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; mem_read_i = 1'b0;
      mem_write_i = 1'b0; indirect_i = 1'b0; opcode_i = op_br; byte_en_i = 2'b00;
      addr_i = 16'h0000; wdata_i = 16'h0000;
      set_resp(1'b0, 16'h0000);
      next_cycle(); next_cycle();
      reset_n = 1'b1;
      next_cycle();
      #1;
      chk("rst_read", bus.dmem_read, 0);
      chk("rst_write", bus.dmem_write, 0);
      chk("rst_addr", bus.dmem_address, 16'h0000);
      chk("rst_stall", stall_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rdata", rdata_o, 16'h0000);
      chk("rst_timeout", timeout_err, 0);

      // LDR 0x1234, three wait cycles then 0xBEEF
      exp_q.push_back(16'hBEEF);
      drive_req(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h1234, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ldr_wait_read", bus.dmem_read, 1);
         chk("ldr_wait_addr", bus.dmem_address, 16'h1234);
         chk("ldr_wait_be", bus.dmem_byte_enable, 2'b11);
         chk("ldr_wait_stall", stall_o, 1);
         chk("ldr_wait_done", done_o, 0);
         next_cycle();
      end
      set_resp(1'b1, 16'hBEEF);
      #1;
      chk("ldr_resp_read", bus.dmem_read, 1);
      chk("ldr_resp_done", done_o, 1);
      chk("ldr_resp_stall", stall_o, 0);
      chk("ldr_resp_rdata", rdata_o, 16'hBEEF);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("ldr_idle_read", bus.dmem_read, 0);
      chk("ldr_hold_rdata", rdata_o, 16'hBEEF);
      chk("ldr_idle_done", done_o, 0);

      // STB 0x2001, byte_en 10, immediate response
      exp_q.push_back(16'hBEEF);
      drive_req(op_stb, 1'b0, 1'b1, 1'b0, 2'b10, 16'h2001, 16'hAB00);
      set_resp(1'b1, 16'h0000);
      #1;
      chk("stb_write", bus.dmem_write, 1);
      chk("stb_read", bus.dmem_read, 0);
      chk("stb_be", bus.dmem_byte_enable, 2'b10);
      chk("stb_addr", bus.dmem_address, 16'h2001);
      chk("stb_wdata", bus.dmem_wdata, 16'hAB00);
      chk("stb_done", done_o, 1);
      chk("stb_stall", stall_o, 0);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("stb_idle_write", bus.dmem_write, 0);

      // LDI 0x3000 -> pointer 0x4005 -> data 0x7777
      exp_q.push_back(16'h7777);
      drive_req(op_ldi, 1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000);
      set_resp(1'b1, 16'h4005);
      #1;
      chk("ldi_a1_addr", bus.dmem_address, 16'h3000);
      chk("ldi_a1_done", done_o, 0);
      chk("ldi_a1_stall", stall_o, 1);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("ldi_a2_read", bus.dmem_read, 1);
      chk("ldi_a2_addr", bus.dmem_address, 16'h4004);
      chk("ldi_a2_stall", stall_o, 1);
      next_cycle();
      set_resp(1'b1, 16'h7777);
      #1;
      chk("ldi_done", done_o, 1);
      chk("ldi_rdata", rdata_o, 16'h7777);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("ldi_hold_rdata", rdata_o, 16'h7777);

      // STI 0x3000 -> pointer 0x5000, write 0x1111
      exp_q.push_back(16'h7777);
      drive_req(op_sti, 1'b0, 1'b1, 1'b1, 2'b11, 16'h3000, 16'h1111);
      set_resp(1'b1, 16'h5000);
      #1;
      chk("sti_a1_read", bus.dmem_read, 1);
      chk("sti_a1_write", bus.dmem_write, 0);
      chk("sti_a1_done", done_o, 0);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("sti_a2_write", bus.dmem_write, 1);
      chk("sti_a2_read", bus.dmem_read, 0);
      chk("sti_a2_addr", bus.dmem_address, 16'h5000);
      chk("sti_a2_be", bus.dmem_byte_enable, 2'b11);
      chk("sti_a2_wdata", bus.dmem_wdata, 16'h1111);
      next_cycle();
      set_resp(1'b1, 16'hDEAD);
      #1;
      chk("sti_done", done_o, 1);
      chk("sti_rdata", rdata_o, 16'h7777);
      next_cycle();
      set_resp(1'b0, 16'h0000);

      // Back-to-back LDR in the IDLE cycle right after completion
      exp_q.push_back(16'h00AA);
      drive_req(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0042, 16'h0000);
      set_resp(1'b1, 16'h00AA);
      #1;
      chk("b2b_addr", bus.dmem_address, 16'h0042);
      chk("b2b_done", done_o, 1);
      next_cycle();
      set_resp(1'b0, 16'h0000);

      // LDI squashed by a flush pulse during ACCESS1
      drive_req(op_ldi, 1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000);
      flush_i = 1'b1;
      #1;
      chk("flush_read", bus.dmem_read, 1);
      chk("flush_stall", stall_o, 1);
      next_cycle();
      flush_i = 1'b0;
      set_resp(1'b1, 16'h4005);
      #1;
      chk("flush_resp_done", done_o, 0);
      chk("flush_resp_stall", stall_o, 0);
      chk("flush_resp_rdata", rdata_o, 16'h00AA);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("flush_no_read", bus.dmem_read, 0);
      chk("flush_no_write", bus.dmem_write, 0);
      chk("flush_idle_stall", stall_o, 0);
      next_cycle();
      chk("flush_no_second", bus.dmem_read, 0);
      chk("flush_keep_rdata", rdata_o, 16'h00AA);

      // Asynchronous reset while in ACCESS2
      drive_req(op_ldi, 1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000);
      set_resp(1'b1, 16'h4005);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("rst2_pre_addr", bus.dmem_address, 16'h4004);
      reset_n = 1'b0;
      #1;
      chk("rst2_read", bus.dmem_read, 0);
      chk("rst2_addr", bus.dmem_address, 16'h0000);
      chk("rst2_be", bus.dmem_byte_enable, 2'b00);
      chk("rst2_stall", stall_o, 0);
      chk("rst2_done", done_o, 0);
      chk("rst2_rdata", rdata_o, 16'h0000);
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
      exp_q.push_back(16'h1357);
      drive_req(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000);
      set_resp(1'b1, 16'h1357);
      #1;
      chk("post_rst_done", done_o, 1);
      chk("post_rst_rdata", rdata_o, 16'h1357);
      next_cycle();
      set_resp(1'b0, 16'h0000);

      // Watchdog: four ACCESS cycles without a response
      exp_q.push_back(16'h2468);
      drive_req(op_ldr, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0200, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("wd_not_yet", timeout_err, 0);
         next_cycle();
      end
      #1;
      chk("wd_set", timeout_err, 1);
      chk("wd_still_read", bus.dmem_read, 1);
      next_cycle();
      set_resp(1'b1, 16'h2468);
      #1;
      chk("wd_late_done", done_o, 1);
      next_cycle();
      set_resp(1'b0, 16'h0000);
      #1;
      chk("wd_sticky", timeout_err, 1);

      next_cycle();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("done_count", 32'(done_seen), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_sequencer.md
Name: mem_stage_sequencer

Overview:
- Responder to the decoded control word's memory fields (mem_read, mem_write, mem_byte_enable, indirect_enable, opcode) in the MEM stage of the pipelined LC-3b.
- Turns those fields into a request/response transaction sequence on the data-cache port.
- Performs the two-access sequence for LDI/STI and stalls the pipeline until the final access completes.
- Returns load data to the writeback path.

Parameters:
- DATA_WIDTH, 16: word and address width. Only 16 is supported; it is declared for port sizing.
- TIMEOUT_CYCLES, 0: cycles without dmem_resp before timeout_err is set. 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_i  in  1  MEM-stage instruction is valid, i.e. not is_nop.
- flush_i  in  1  squash the current MEM-stage instruction.
- opcode_i  in  lc3b_opcode  opcode field of the control word.
- mem_read_i  in  1  control word mem_read.
- mem_write_i  in  1  control word mem_write.
- indirect_i  in  1  control word indirect_enable.
- byte_en_i  in  2  control word mem_byte_enable.
- addr_i  in  16  effective address (MAR value).
- wdata_i  in  16  store data (MDR value, already byte-filtered for STB).
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_byte_enable  out  2  cache byte enables.
- dmem_address  out  16  cache address.
- dmem_wdata  out  16  cache write data.
- dmem_rdata  in  16  cache read data.
- dmem_resp  in  1  cache response, single-cycle pulse.
- stall_o  out  1  hold all upstream pipeline registers.
- done_o  out  1  final access completed this cycle.
- rdata_o  out  16  load result.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- req = valid_i & ~flush_i & (mem_read_i | mem_write_i). If mem_read_i and mem_write_i are both set, the write wins and an assertion fires.
- States: IDLE, ACCESS1, ACCESS2.
- IDLE:
  - dmem_* requests are 0.
  - On req: stall_o=1 combinationally; latch addr, wdata, byte_en, kind (load/store/ldi/sti); next state is ACCESS1.
- ACCESS1:
  - dmem_address = latched addr.
  - A store (non-indirect) drives dmem_write=1, dmem_byte_enable = latched byte_en, dmem_wdata = latched wdata.
  - A load, LDI or STI drives dmem_read=1 with byte_enable 11.
  - All outputs are held stable until dmem_resp.
  - On dmem_resp, non-indirect: done_o=1, stall_o=0 in that cycle, rdata_o = dmem_rdata (passthrough), data register loaded; next state is IDLE.
  - On dmem_resp, indirect: pointer register = dmem_rdata; next state is ACCESS2; stall_o stays 1.
- ACCESS2:
  - dmem_address = {ptr[15:1],1'b0}.
  - LDI: dmem_read=1.
  - STI: dmem_write=1, byte_enable 11, wdata = latched wdata.
  - On dmem_resp: done_o=1, stall_o=0; LDI also drives and latches rdata_o; next state is IDLE.
- Latency: minimum 2 cycles (req cycle, then one resp cycle) for direct accesses; minimum 3 cycles for indirect.
- rdata_o when not passthrough = data register. It holds its value until the next completed load.
- Requests are never issued in the req-detect cycle. The dmem port is fully registered from state and latches.
- Flush:
  - In IDLE, flush_i suppresses req.
  - In ACCESS1/ACCESS2, the outstanding cache access is never aborted. A squash flag is set, the current access runs to dmem_resp, ACCESS2 is skipped, done_o stays 0, the data register is not updated, and the next state is IDLE.
  - stall_o still deasserts on that resp.
- Back-to-back: a new req in the IDLE cycle after done is accepted normally, giving no bubble beyond the detect cycle.
- Watchdog (TIMEOUT_CYCLES>0): a counter clears on state entry and on resp, and increments while in ACCESSx. Reaching TIMEOUT_CYCLES sets timeout_err, which is cleared only by reset. The FSM keeps waiting.
- Reset (asynchronous, any state): state=IDLE; dmem_read=0, dmem_write=0, dmem_byte_enable=00, dmem_address=0, dmem_wdata=0, stall_o=0, done_o=0, rdata_o=0, timeout_err=0; squash, pointer and counter cleared. An in-flight cache access is abandoned.

Decomposition:
- lc3b_types gains:
  - mem_seq_state_t enum (IDLE, ACCESS1, ACCESS2);
  - mem_kind_t enum (MK_LOAD, MK_STORE, MK_LDI, MK_STI);
  - constant BE_WORD = 2'b11.
- One natural sub-module: mem_seq_watchdog (counter plus sticky error).

Test Plan:
- LDR addr 0x1234, resp after 3 wait cycles, rdata 0xBEEF -> dmem_read held 3 cycles at 0x1234 with BE 11; stall_o=1 until the resp cycle; done_o pulse; rdata_o=0xBEEF and held.
- STB addr 0x2001, byte_en 10, wdata 0xAB00, immediate resp -> dmem_write with BE 10 and wdata 0xAB00 for 1 cycle; done_o; total stall 1 cycle.
- LDI addr 0x3000: first resp returns 0x4005, second resp returns 0x7777 -> second read at 0x4004; done_o only on the second resp; rdata_o=0x7777.
- STI addr 0x3000: pointer 0x5000, wdata 0x1111 -> read at 0x3000, then write at 0x5000 with BE 11 and wdata 0x1111; one done_o.
- LDI with flush_i pulsed during ACCESS1 -> first read completes; no second access; done_o=0; rdata_o unchanged; back to IDLE.
- reset_n low during ACCESS2 -> all outputs 0 immediately; after release, a new LDR completes normally. With TIMEOUT_CYCLES=4 and no resp -> timeout_err=1 after 4 cycles and stays set.
